// File: rtl/ebpc_blk_sched_if.sv
// Stream bundle between the input port, the block scheduler and the encoder.
// The scheduler connects through the slave modport; the upstream/encoder side
// (or a bench) uses the master modport.
interface ebpc_blk_sched_if #(
  parameter int DATA_W          = 8,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Input side of the scheduler
  logic [DATA_W-1:0] data_i;
  logic              last_i;
  logic              vld_i;
  logic              rdy_o;

  // Encoder side of the scheduler
  logic [DATA_W-1:0] data_o;
  logic              vld_o;
  logic              rdy_i;
  logic              blk_last_o;
  logic              frm_last_o;
  logic              blk_done_i;

  // Status
  logic [OUT_W-1:0]  outstanding_o;
  logic              idle_o;
  logic              err_o;

  modport slave (
    input  data_i, last_i, vld_i, rdy_i, blk_done_i,
    output rdy_o, data_o, vld_o, blk_last_o, frm_last_o,
           outstanding_o, idle_o, err_o
  );

  modport master (
    output data_i, last_i, vld_i, rdy_i, blk_done_i,
    input  rdy_o, data_o, vld_o, blk_last_o, frm_last_o,
           outstanding_o, idle_o, err_o
  );
endinterface

// File: rtl/ebpc_blk_sched.sv
// ebpc_blk_sched: splits the input word stream into BLOCK_SIZE-word blocks,
// tags block/frame ends and gates block starts on a credit count of blocks in
// flight (credits come back on the encoder's blk_done_i pulse).
// Optional feature macro: EBPC_BLK_SCHED_PAD_EN -- when defined, a partial
// final block is completed with zero words (PAD state); otherwise the final
// block is truncated at last_i.
// The interface instance must use the same DATA_W / MAX_OUTSTANDING values.
module ebpc_blk_sched #(
  parameter int BLOCK_SIZE      = 8,
  parameter int DATA_W          = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  ebpc_blk_sched_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_SIZE);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [OUT_W-1:0]  out_reg, out_next;
  logic              err_reg, err_next;
  logic              go;
  logic              vld, rdy, hs, blk_last, frm_last, inc;
  logic [DATA_W-1:0] data;

`ifdef EBPC_BLK_SCHED_PAD_EN
  typedef enum logic {FILL, PAD} state_t;
  state_t state_reg, state_next;

  // State register; reset abandons any partial block or padding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= FILL;
    else       state_reg <= state_next;
  end
`endif

  // Word counter, credit counter and sticky underflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      out_reg <= out_next;
      err_reg <= err_next;
    end
  end

  // A started block always finishes; a new block needs a free credit.
  // Built from registers only, so no loop through vld_i/rdy_i.
  assign go = (cnt_reg != '0) || (out_reg < OUT_MAX);

  // Datapath muxing, block/frame tagging and next-state logic
  always_comb begin
    vld      = bus.vld_i & go;
    rdy      = bus.rdy_i & go;
    data     = bus.data_i;
`ifdef EBPC_BLK_SCHED_PAD_EN
    blk_last = (cnt_reg == CNT_LAST);
    state_next = state_reg;
`else
    // Without padding the frame end closes the block early
    blk_last = (cnt_reg == CNT_LAST) | bus.last_i;
`endif
    frm_last = bus.last_i & blk_last;
    cnt_next = cnt_reg;

`ifdef EBPC_BLK_SCHED_PAD_EN
    if (state_reg == PAD) begin
      // Inject zeros until the block is full; input is held off meanwhile
      vld      = 1'b1;
      rdy      = 1'b0;
      data     = '0;
      frm_last = blk_last;
    end
`endif

    hs = vld & bus.rdy_i;
    if (hs) begin
      cnt_next = blk_last ? '0 : cnt_reg + 1'b1;
`ifdef EBPC_BLK_SCHED_PAD_EN
      if (state_reg == FILL && bus.last_i && !blk_last) state_next = PAD;
      if (state_reg == PAD && blk_last)                 state_next = FILL;
`endif
    end
  end

  // Credit accounting: a block leaves on its last-word handshake and returns
  // on blk_done_i; a done with nothing in flight is flagged, not counted
  always_comb begin
    inc      = hs & blk_last;
    out_next = out_reg;
    err_next = err_reg;
    if (inc && !bus.blk_done_i) begin
      out_next = out_reg + 1'b1;
    end else if (!inc && bus.blk_done_i) begin
      if (out_reg == '0) err_next = 1'b1;
      else               out_next = out_reg - 1'b1;
    end
  end

  assign bus.vld_o         = vld;
  assign bus.rdy_o         = rdy;
  assign bus.data_o        = data;
  assign bus.blk_last_o    = blk_last;
  assign bus.frm_last_o    = frm_last;
  assign bus.outstanding_o = out_reg;
  assign bus.err_o         = err_reg;
`ifdef EBPC_BLK_SCHED_PAD_EN
  assign bus.idle_o = (state_reg == FILL) && (cnt_reg == '0) && (out_reg == '0);
`else
  assign bus.idle_o = (cnt_reg == '0) && (out_reg == '0);
`endif
endmodule

// File: tb/tb_ebpc_blk_sched.sv
// Directed bench for ebpc_blk_sched (BLOCK_SIZE 8, DATA_W 8, MAX_OUTSTANDING 2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ebpc_blk_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ebpc_blk_sched_if #(.DATA_W(8), .MAX_OUTSTANDING(2)) bus ();

  ebpc_blk_sched #(.BLOCK_SIZE(8), .DATA_W(8), .MAX_OUTSTANDING(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, then let combinational outputs settle
  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic r, input logic dn);
    @(negedge clk);
    bus.vld_i = v; bus.data_i = d; bus.last_i = l; bus.rdy_i = r; bus.blk_done_i = dn;
    #1;
    if (bus.vld_o && bus.rdy_i)
      $display("tx data=%02h blk_last=%0b frm_last=%0b outstanding=%0d",
               bus.data_o, bus.blk_last_o, bus.frm_last_o, bus.outstanding_o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vld_i = 0; bus.data_i = 0; bus.last_i = 0; bus.rdy_i = 1; bus.blk_done_i = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err_o); end
    checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b exp=1", bus.idle_o); end
    checks++; if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", bus.vld_o); end
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%0b exp=1", bus.rdy_o); end
    checks++; if (bus.blk_last_o !== 1'b0 || bus.frm_last_o !== 1'b0) begin errors++;
      $display("FAIL reset_last got=%0b/%0b exp=0/0", bus.blk_last_o, bus.frm_last_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 16 words, done pulses 3 cycles after each block end
  task automatic test_stream();
    logic exp_bl;
    logic [1:0] exp_out;
    for (int c = 0; c < 20; c++) begin
      cyc(c < 16, 8'(c + 1), 1'b0, 1'b1, (c == 10) || (c == 18));
      exp_out = ((c >= 8 && c <= 10) || (c >= 16 && c <= 18)) ? 2'd1 : 2'd0;
      checks++; if (bus.outstanding_o !== exp_out) begin errors++;
        $display("FAIL stream_outstanding cyc=%0d got=%0d exp=%0d", c, bus.outstanding_o, exp_out); end
      if (c < 16) begin
        exp_bl = (c == 7) || (c == 15);
        checks++; if (bus.blk_last_o !== exp_bl || bus.vld_o !== 1'b1 || bus.data_o !== 8'(c + 1)) begin errors++;
          $display("FAIL stream_word cyc=%0d got vld=%0b data=%02h bl=%0b exp vld=1 data=%02h bl=%0b",
                   c, bus.vld_o, bus.data_o, bus.blk_last_o, 8'(c + 1), exp_bl); end
      end
    end
    checks++; if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL stream_idle got=%0b exp=1", bus.idle_o); end
  endtask

  // Two blocks in flight exhaust the credits; one done releases word 17
  task automatic test_credit_stall();
    for (int c = 0; c < 16; c++) begin
      cyc(1'b1, 8'(c + 1), 1'b0, 1'b1, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.rdy_o !== 1'b1) begin errors++;
        $display("FAIL stall_pass cyc=%0d got vld=%0b rdy=%0b exp 1/1", c, bus.vld_o, bus.rdy_o); end
    end
    for (int c = 16; c < 19; c++) begin
      cyc(1'b1, 8'd17, 1'b0, 1'b1, c == 18);
      checks++; if (bus.vld_o !== 1'b0 || bus.rdy_o !== 1'b0 || bus.outstanding_o !== 2'd2) begin errors++;
        $display("FAIL stall_hold cyc=%0d got vld=%0b rdy=%0b out=%0d exp 0/0/2", c, bus.vld_o, bus.rdy_o, bus.outstanding_o); end
    end
    for (int w = 17; w <= 24; w++) begin
      cyc(1'b1, 8'(w), 1'b0, 1'b1, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.rdy_o !== 1'b1 || bus.data_o !== 8'(w) || bus.blk_last_o !== (w == 24)) begin errors++;
        $display("FAIL stall_resume word=%0d got vld=%0b rdy=%0b data=%02h bl=%0b", w, bus.vld_o, bus.rdy_o, bus.data_o, bus.blk_last_o); end
      if (w == 17) begin
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL stall_release got=%0d exp=1", bus.outstanding_o); end
      end
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd2) begin errors++; $display("FAIL stall_full got=%0d exp=2", bus.outstanding_o); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.outstanding_o !== 2'd0 || bus.idle_o !== 1'b1) begin errors++;
      $display("FAIL stall_drain got out=%0d idle=%0b exp 0/1", bus.outstanding_o, bus.idle_o); end
  endtask

  // Frame ending on word 3 of a block
  task automatic test_last();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 8'(c + 1), c == 2, 1'b1, 1'b0);
`ifdef EBPC_BLK_SCHED_PAD_EN
      checks++; if (bus.blk_last_o !== 1'b0 || bus.rdy_o !== 1'b1) begin errors++;
        $display("FAIL last_head cyc=%0d got bl=%0b rdy=%0b exp 0/1", c, bus.blk_last_o, bus.rdy_o); end
`else
      checks++; if (bus.blk_last_o !== (c == 2) || bus.frm_last_o !== (c == 2)) begin errors++;
        $display("FAIL last_trunc cyc=%0d got bl=%0b fl=%0b exp %0b/%0b", c, bus.blk_last_o, bus.frm_last_o, c == 2, c == 2); end
`endif
    end
`ifdef EBPC_BLK_SCHED_PAD_EN
    for (int c = 3; c < 8; c++) begin
      cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.rdy_o !== 1'b0 || bus.data_o !== 8'd0 ||
                    bus.blk_last_o !== (c == 7) || bus.frm_last_o !== (c == 7)) begin errors++;
        $display("FAIL last_pad cyc=%0d got vld=%0b rdy=%0b data=%02h bl=%0b fl=%0b", c, bus.vld_o, bus.rdy_o,
                 bus.data_o, bus.blk_last_o, bus.frm_last_o); end
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd1 || bus.idle_o !== 1'b0) begin errors++;
      $display("FAIL last_credit got out=%0d idle=%0b exp 1/0", bus.outstanding_o, bus.idle_o); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
`else
    for (int c = 3; c < 11; c++) begin
      cyc(1'b1, 8'(c + 1), 1'b0, 1'b1, 1'b0);
      if (c == 3) begin
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL last_credit got=%0d exp=1", bus.outstanding_o); end
      end
      checks++; if (bus.blk_last_o !== (c == 10) || bus.vld_o !== 1'b1) begin errors++;
        $display("FAIL last_next_block cyc=%0d got bl=%0b vld=%0b exp %0b/1", c, bus.blk_last_o, bus.vld_o, c == 10); end
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd2) begin errors++; $display("FAIL last_two got=%0d exp=2", bus.outstanding_o); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
`endif
    checks++; if (bus.outstanding_o !== 2'd0 || bus.idle_o !== 1'b1) begin errors++;
      $display("FAIL last_drain got out=%0d idle=%0b exp 0/1", bus.outstanding_o, bus.idle_o); end
  endtask

  // Simultaneous done + block end, then a done with nothing in flight
  task automatic test_credit_edge();
    for (int c = 0; c < 16; c++) cyc(1'b1, 8'(c), 1'b0, 1'b1, c == 15);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL edge_same_cycle got=%0d exp=1", bus.outstanding_o); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd0 || bus.err_o !== 1'b0) begin errors++;
      $display("FAIL edge_drain got out=%0d err=%0b exp 0/0", bus.outstanding_o, bus.err_o); end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.err_o !== 1'b1 || bus.outstanding_o !== 2'd0) begin errors++;
        $display("FAIL edge_underflow cyc=%0d got err=%0b out=%0d exp 1/0", c, bus.err_o, bus.outstanding_o); end
    end
  endtask

  // Random back-pressure, then reset in the middle of a block (or padding)
  task automatic test_back_pressure_reset();
    int acc = 0;
    int n = 0;
    logic r;
`ifdef EBPC_BLK_SCHED_PAD_EN
    int p = 3;
    while (acc < 3 && n < 60) begin
      r = 1'($urandom_range(0, 1));
      cyc(1'b1, 8'(8'h30 + acc), acc == 2, r, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.data_o !== 8'(8'h30 + acc) || bus.blk_last_o !== 1'b0) begin errors++;
        $display("FAIL bp_word n=%0d got vld=%0b data=%02h bl=%0b", n, bus.vld_o, bus.data_o, bus.blk_last_o); end
      if (r) acc++;
      n++;
    end
    while (p < 5 && n < 60) begin
      r = 1'($urandom_range(0, 1));
      cyc(1'b0, 8'd0, 1'b0, r, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.rdy_o !== 1'b0 || bus.data_o !== 8'd0 || bus.blk_last_o !== 1'b0) begin errors++;
        $display("FAIL bp_pad n=%0d got vld=%0b rdy=%0b data=%02h bl=%0b", n, bus.vld_o, bus.rdy_o, bus.data_o, bus.blk_last_o); end
      if (r) p++;
      n++;
    end
`else
    while (acc < 5 && n < 60) begin
      r = 1'($urandom_range(0, 1));
      cyc(1'b1, 8'(8'h30 + acc), 1'b0, r, 1'b0);
      checks++; if (bus.vld_o !== 1'b1 || bus.data_o !== 8'(8'h30 + acc) || bus.blk_last_o !== 1'b0) begin errors++;
        $display("FAIL bp_word n=%0d got vld=%0b data=%02h bl=%0b", n, bus.vld_o, bus.data_o, bus.blk_last_o); end
      if (r) acc++;
      n++;
    end
`endif
    checks++; if (n >= 60) begin errors++; $display("FAIL bp_timeout got=%0d cycles exp<60", n); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.vld_i = 0; bus.last_i = 0; bus.rdy_i = 1; bus.blk_done_i = 0;
    #1;
    checks++; if (bus.vld_o !== 1'b0 || bus.rdy_o !== 1'b1 || bus.blk_last_o !== 1'b0 || bus.frm_last_o !== 1'b0) begin errors++;
      $display("FAIL bp_reset_io got vld=%0b rdy=%0b bl=%0b fl=%0b exp 0/1/0/0", bus.vld_o, bus.rdy_o, bus.blk_last_o, bus.frm_last_o); end
    checks++; if (bus.idle_o !== 1'b1 || bus.outstanding_o !== 2'd0 || bus.err_o !== 1'b0) begin errors++;
      $display("FAIL bp_reset_state got idle=%0b out=%0d err=%0b exp 1/0/0", bus.idle_o, bus.outstanding_o, bus.err_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 8'(8'h50 + c), 1'b0, 1'b1, 1'b0);
      checks++; if (bus.blk_last_o !== (c == 7) || bus.vld_o !== 1'b1) begin errors++;
        $display("FAIL bp_after_reset cyc=%0d got bl=%0b vld=%0b exp %0b/1", c, bus.blk_last_o, bus.vld_o, c == 7); end
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL bp_after_credit got=%0d exp=1", bus.outstanding_o); end
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit_stall();
    test_last();
    test_credit_edge();
    test_back_pressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ebpc_blk_sched.md
# ebpc_blk_sched

Block scheduler ahead of the EBPC encoder datapath. Splits the incoming word stream into blocks of `BLOCK_SIZE` words, tags the last word of each block and frame, and throttles block starts with a credit count of blocks in flight. Credits are returned by the encoder's one-cycle block-done pulse. It sits between the input stream port and the ZNZ/BPC split.

## Interface

Parameters:
- `BLOCK_SIZE`, 8: words per block, ≥2.
- `DATA_W`, 8: word width.
- `MAX_OUTSTANDING`, 2: maximum number of blocks in flight, ≥1.
- Derived: `CNT_W = $clog2(BLOCK_SIZE)`, `OUT_W = $clog2(MAX_OUTSTANDING+1)`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `data_i` in `DATA_W`: input word.
- `last_i` in 1: last word of frame, qualified by `vld_i`.
- `vld_i` in 1: input valid.
- `rdy_o` out 1: input ready.
- `data_o` out `DATA_W`: word to encoder.
- `vld_o` out 1: output valid.
- `rdy_i` in 1: encoder ready.
- `blk_last_o` out 1: last word of block, qualified by `vld_o`.
- `frm_last_o` out 1: last word of frame, qualified by `vld_o`.
- `blk_done_i` in 1: one-cycle pulse from the encoder; one block fully emitted.
- `outstanding_o` out `OUT_W`: blocks in flight.
- `idle_o` out 1: no partial block and nothing in flight.
- `err_o` out 1: sticky; `blk_done_i` was received with no blocks in flight.

## Operation

- Two states: FILL (pass-through) and PAD (zero injection). The word counter `cnt` runs from 0 to `BLOCK_SIZE-1`.
- Gate `go` = (`cnt != 0`) or (`outstanding < MAX_OUTSTANDING`). A new block may start only while a credit is free. A block already started always completes.
- Behaviour in FILL:
  - `vld_o = vld_i & go`, `rdy_o = rdy_i & go`, `data_o = data_i`.
  - `blk_last_o = (cnt == BLOCK_SIZE-1)`.
  - `frm_last_o = last_i & blk_last_o`.
- On a handshake in FILL (`vld_o & rdy_i`):
  - `cnt` increments and wraps to 0 after `BLOCK_SIZE-1`.
  - If `last_i` is high and `cnt != BLOCK_SIZE-1`, go to PAD (see Configuration).
- Behaviour in PAD:
  - `vld_o = 1`, `data_o = 0`, `rdy_o = 0`.
  - `blk_last_o = (cnt == BLOCK_SIZE-1)`; `frm_last_o = blk_last_o`.
  - `cnt` increments on each `rdy_i`. After the handshake at `cnt == BLOCK_SIZE-1`, `cnt` returns to 0 and the state returns to FILL.
- Credit counter `outstanding`:
  - +1 on the handshake of any word with `blk_last_o = 1`.
  - −1 on `blk_done_i`.
  - Both in the same cycle: no change.
  - `blk_done_i` at 0 with no simultaneous increment: the count stays 0 and `err_o` is set.
  - Increment when the count is already at `MAX_OUTSTANDING` cannot occur, because of `go`.
- `idle_o = (state == FILL) & (cnt == 0) & (outstanding == 0)`.

## Timing

- Zero-latency combinational path `data_i`→`data_o`, `vld_i`→`vld_o`, `rdy_i`→`rdy_o`. No storage of data.
- `go` depends on registered state only, so there is no combinational loop with `vld_i`/`rdy_i`.
- `outstanding_o` updates the cycle after the event. A `blk_done_i` in cycle t lets a new block start in cycle t+1.
- Protocol rules:
  - `vld_o` is held until `rdy_i` (AXI-stream style).
  - `vld_o` never depends on `rdy_i`.
- Reset values: state FILL, `cnt` 0, `outstanding_o` 0, `err_o` 0, `idle_o` 1. With `vld_i` = 0: `vld_o` 0, `rdy_o` = `rdy_i`, `blk_last_o` 0, `frm_last_o` 0.
- Reset asserted mid-block or in PAD: all state clears immediately. The partial block is abandoned and no done is expected for it.
- `last_i` on word `BLOCK_SIZE-1`: no PAD; the frame ends exactly on the block boundary.

## Configuration

- `EBPC_BLK_SCHED_PAD_EN` defined: a partial final block is completed with zero words in PAD as described above.
- Not defined:
  - PAD state is not built.
  - `blk_last_o = (cnt == BLOCK_SIZE-1) | last_i`.
  - A handshake with `last_i` resets `cnt` to 0 and counts as a block for credits, so the final block is truncated.

## Test plan

- Reset, then 16 words with `rdy_i` = 1 and `blk_done_i` pulsed 3 cycles after each block → `blk_last_o` on words 8 and 16; `outstanding_o` goes 1,0,1,0; `idle_o` = 1 at the end.
- `MAX_OUTSTANDING` = 2, 24 words offered, no `blk_done_i` → words 1–16 pass; word 17 stalls (`rdy_o` = 0, `vld_o` = 0); one `blk_done_i` → word 17 is accepted the next cycle.
- `last_i` on word 3 with PAD_EN → 5 zero words follow with `rdy_o` = 0; `blk_last_o` and `frm_last_o` on the 8th; `outstanding_o` = 1.
- Same stimulus without PAD_EN → `blk_last_o` and `frm_last_o` on word 3, no padding, and the next word starts at `cnt` = 0.
- `blk_done_i` and a `blk_last_o` handshake in the same cycle at `outstanding_o` = 1 → stays 1; `blk_done_i` at 0 → `err_o` = 1 and stays set until reset.
- Random `rdy_i` back-pressure with reset asserted during PAD → outputs return to reset values the same cycle, with no spurious `blk_last_o`.
